// File: rtl/afifo_pkg.sv
// Shared async FIFO types and gray-code helpers.
// Used by both the read-domain and write-domain control blocks.
package afifo_pkg;

    localparam int PTR_W = 9;
    localparam int CODE_W = 32;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic logic [CODE_W-1:0] bin2gray(
        input logic [CODE_W-1:0] b
    );
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(
        input logic [CODE_W-1:0] g
    );
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_sync_2ff.sv
// Two-flop synchroniser for a gray pointer crossing clock domains.
// Reset clears both stages to zero.
module afifo_sync_2ff #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    // Plain flop chain, no logic between stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/afifo_rd_ctrl.sv
// Async FIFO read-domain control: read pointer, synchronised write
// pointer, and empty / almost-empty / level / underflow status.
module afifo_rd_ctrl
    import afifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  runderflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]     rbin;
    logic [PW-1:0]     rbin_next;
    logic [PW-1:0]     rgray_next;
    logic [PW-1:0]     rq2;
    logic [PW-1:0]     wbin_sync;
    logic [PW-1:0]     level_next;
    logic [CODE_W-1:0] rgray_w;
    logic [CODE_W-1:0] wbin_w;
    logic              rd_en;
    logic              unused;

    afifo_sync_2ff #(
        .WIDTH (PW)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr_gray),
        .q     (rq2)
    );

    // Next-state pointer and occupancy from the synchronised write pointer.
    always_comb begin
        rd_en      = rinc & ~rempty;
        rbin_next  = rbin + PW'(rd_en);
        rgray_w    = bin2gray(CODE_W'(rbin_next));
        rgray_next = rgray_w[PW-1:0];
        wbin_w     = gray2bin(CODE_W'(rq2));
        wbin_sync  = wbin_w[PW-1:0];
        level_next = wbin_sync - rbin_next;
    end

    assign unused = ^{rgray_w[CODE_W-1:PW], wbin_w[CODE_W-1:PW]};

    // Pointer, status and sticky underflow registers.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr_gray  <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbin_next;
            rptr_gray  <= rgray_next;
            rempty     <= (rgray_next == rq2);
            raempty    <= (int'(level_next) <= AEMPTY_THRESH);
            rlevel     <= level_next;
            runderflow <= runderflow | (rinc & rempty);
        end
    end

    assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Self-checking bench for afifo_rd_ctrl (ADDR_WIDTH=3, AEMPTY_THRESH=2)
// against a count-based occupancy model.
module tb_afifo_rd_ctrl;

    localparam int AW = 3;
    localparam int TH = 2;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          rinc;
    logic [AW:0]   wptr_gray;
    logic [AW:0]   rptr_gray;
    logic [AW-1:0] raddr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rlevel;
    logic          runderflow;

    int tests = 0;
    int fails = 0;

    // Model: true counts of words written and read.
    int wcnt;
    int rcnt;
    int w1;
    int w2;
    int m_level;
    bit m_empty;
    bit m_aempty;
    bit m_uf;
    bit m_pop;
    int max_level;
    logic [AW:0] prev_gray;

    afifo_rd_ctrl #(
        .ADDR_WIDTH    (AW),
        .AEMPTY_THRESH (TH)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .wptr_gray  (wptr_gray),
        .rptr_gray  (rptr_gray),
        .raddr      (raddr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [AW:0] g4(input int v);
        logic [AW:0] b;
        b = (AW+1)'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rempty", int'(rempty), int'(m_empty));
        chk("raempty", int'(raempty), int'(m_aempty));
        chk("rlevel", int'(rlevel), m_level);
        chk("raddr", int'(raddr), rcnt % 8);
        chk("rptr_gray", int'(rptr_gray), int'(g4(rcnt % 16)));
        chk("runderflow", int'(runderflow), int'(m_uf));
    endtask

    // One rclk edge: drive inputs, advance model, check after the edge.
    task automatic step(input bit inc, input bit rst_n_v);
        rinc      = inc;
        rrst_n    = rst_n_v;
        wptr_gray = g4(wcnt % 16);
        prev_gray = rptr_gray;
        @(posedge rclk);
        if (!rst_n_v) begin
            rcnt     = 0;
            w1       = 0;
            w2       = 0;
            m_level  = 0;
            m_empty  = 1;
            m_aempty = 1;
            m_uf     = 0;
            m_pop    = 0;
        end else begin
            m_pop = inc && !m_empty;
            if (inc && m_empty) m_uf = 1;
            if (m_pop) rcnt++;
            m_level  = w2 - rcnt;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= TH);
            w2 = w1;
            w1 = wcnt;
        end
        #1;
        check_all();
        if (m_level > max_level) max_level = m_level;
    endtask

    initial begin
        wcnt      = 0;
        rcnt      = 0;
        w1        = 0;
        w2        = 0;
        m_level   = 0;
        m_empty   = 1;
        m_aempty  = 1;
        m_uf      = 0;
        max_level = 0;
        rinc      = 1'b0;
        rrst_n    = 1'b0;
        wptr_gray = '0;

        // Reset held with rinc high.
        repeat (3) step(1'b1, 1'b0);

        // Five words written; status appears on the third edge only.
        wcnt = 5;
        step(1'b0, 1'b1);
        chk("empty_edge1", int'(rempty), 1);
        step(1'b0, 1'b1);
        chk("empty_edge2", int'(rempty), 1);
        step(1'b0, 1'b1);
        chk("empty_edge3", int'(rempty), 0);
        chk("level_edge3", int'(rlevel), 5);

        // Drain five words.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            chk("gray_onebit", $countones(prev_gray ^ rptr_gray), 1);
        end
        chk("drain_empty", int'(rempty), 1);
        chk("drain_raddr", int'(raddr), 5);

        // Underflow: pointer holds, flag sticks.
        step(1'b1, 1'b1);
        chk("uf_raddr", int'(raddr), 5);
        chk("uf_flag", int'(runderflow), 1);

        // Fill to full and confirm level 8 reported.
        wcnt = rcnt + 8;
        repeat (3) step(1'b0, 1'b1);
        chk("full_level", int'(rlevel), 8);

        // Random stream with the writer never exceeding depth.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1 && wcnt - rcnt < 8) wcnt++;
            step(1'($urandom_range(0, 1)), 1'b1);
            chk("gray_step", $countones(prev_gray ^ rptr_gray),
                m_pop ? 1 : 0);
        end
        chk("max_level", int'(max_level <= 8), 1);

        // Settle at level 3, then reset mid-stream.
        repeat (12) step(1'b1, 1'b1);
        wcnt = rcnt + 3;
        repeat (3) step(1'b0, 1'b1);
        chk("pre_rst_level", int'(rlevel), 3);
        wcnt = 0;
        step(1'b1, 1'b0);
        chk("rst_empty", int'(rempty), 1);
        chk("rst_gray", int'(rptr_gray), 0);
        repeat (4) step(1'b1, 1'b1);
        chk("post_rst_raddr", int'(raddr), 0);
        chk("post_rst_empty", int'(rempty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
